// File: rtl/crc32k_frame_tx.sv
// Transmit framing stage: passes 16-bit payload words through and appends a
// running CRC-32K (high word first) after the last word of each frame.

module crc32k_frame_tx #(
   parameter logic [31:0] INIT      = 32'hFFFFFFFF,
   parameter logic [31:0] POLY      = 32'h741B8CD7,
   parameter logic [31:0] FINAL_XOR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [15:0] m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [31:0] crc_out,
   output logic        crc_done
);

   typedef enum logic [1:0] {StPayload, StCrcHi, StCrcLo} state_e;

   state_e      state_q;
   logic [31:0] crc_q;
   logic        slot_free;
   logic        in_beat;
   logic [31:0] fin;

   // Sixteen serial steps, s_data[0] enters first.
   function automatic logic [31:0] word_step(input logic [31:0] s, input logic [15:0] d);
      logic [31:0] r;
      r = s;
      for (int b = 0; b < 16; b++) begin
         r = {r[30:0], d[b]} ^ ({32{r[31]}} & POLY);
      end
      return r;
   endfunction

   always_comb begin
      slot_free = !m_valid | m_ready;
      s_ready   = (state_q == StPayload) & slot_free;
      in_beat   = s_valid & s_ready;
      fin       = crc_q ^ FINAL_XOR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StPayload;
         crc_q    <= INIT;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         m_data   <= 16'h0000;
         crc_out  <= 32'h0000_0000;
         crc_done <= 1'b0;
      end else begin
         crc_done <= 1'b0;
         case (state_q)
            StPayload: begin
               if (in_beat) begin
                  m_data  <= s_data;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  crc_q   <= word_step(crc_q, s_data);
                  if (s_last) begin
                     state_q <= StCrcHi;
                  end
               end else if (slot_free) begin
                  m_valid <= 1'b0;
               end
            end
            StCrcHi: begin
               if (slot_free) begin
                  m_data   <= fin[31:16];
                  m_valid  <= 1'b1;
                  m_last   <= 1'b0;
                  crc_out  <= fin;
                  crc_done <= 1'b1;
                  state_q  <= StCrcLo;
               end
            end
            StCrcLo: begin
               // Low word comes from crc_out so crc can re-arm in the same cycle.
               if (slot_free) begin
                  m_data  <= crc_out[15:0];
                  m_valid <= 1'b1;
                  m_last  <= 1'b1;
                  crc_q   <= INIT;
                  state_q <= StPayload;
               end
            end
            default: begin
               state_q <= StPayload;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc32k_frame_tx.sv
// Directed bench for crc32k_frame_tx; four instances with different INIT and
// FINAL_XOR share one stimulus stream.

module tb_crc32k_frame_tx;

   logic        clk;
   logic        rst;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        m_ready;

   logic [3:0]        s_ready_w;
   logic [3:0][15:0]  m_data_w;
   logic [3:0]        m_valid_w;
   logic [3:0]        m_last_w;
   logic [3:0][31:0]  crc_out_w;
   logic [3:0]        crc_done_w;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_cnt = 0;
   int mlast_cyc = -1;
   int acc_cyc = -2;
   int done_cnt [4];

   logic [16:0] q0[$];
   logic [16:0] q1[$];
   logic [16:0] q2[$];
   logic [16:0] q3[$];

   // 0: INIT=0, 1: INIT=0x00010000, 2: INIT=0 with inverted output, 3: defaults
   crc32k_frame_tx #(.INIT(32'h0), .FINAL_XOR(32'h0)) u_z (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_w[0]), .m_data(m_data_w[0]), .m_valid(m_valid_w[0]),
      .m_last(m_last_w[0]), .m_ready(m_ready), .crc_out(crc_out_w[0]),
      .crc_done(crc_done_w[0]));

   crc32k_frame_tx #(.INIT(32'h0001_0000)) u_f (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_w[1]), .m_data(m_data_w[1]), .m_valid(m_valid_w[1]),
      .m_last(m_last_w[1]), .m_ready(m_ready), .crc_out(crc_out_w[1]),
      .crc_done(crc_done_w[1]));

   crc32k_frame_tx #(.INIT(32'h0), .FINAL_XOR(32'hFFFF_FFFF)) u_x (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_w[2]), .m_data(m_data_w[2]), .m_valid(m_valid_w[2]),
      .m_last(m_last_w[2]), .m_ready(m_ready), .crc_out(crc_out_w[2]),
      .crc_done(crc_done_w[2]));

   crc32k_frame_tx u_d (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_w[3]), .m_data(m_data_w[3]), .m_valid(m_valid_w[3]),
      .m_last(m_last_w[3]), .m_ready(m_ready), .crc_out(crc_out_w[3]),
      .crc_done(crc_done_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) begin
         if (m_ready) begin
            if (m_valid_w[0]) begin
               q0.push_back({m_last_w[0], m_data_w[0]});
               if (m_last_w[0]) begin
                  last_cnt++;
                  mlast_cyc = cyc;
               end
            end
            if (m_valid_w[1]) q1.push_back({m_last_w[1], m_data_w[1]});
            if (m_valid_w[2]) q2.push_back({m_last_w[2], m_data_w[2]});
            if (m_valid_w[3]) q3.push_back({m_last_w[3], m_data_w[3]});
         end
         if (s_valid && s_ready_w[0]) acc_cyc = cyc;
         for (int i = 0; i < 4; i++) begin
            if (crc_done_w[i]) done_cnt[i]++;
         end
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      int k;
      k = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      #1;
      while (!s_ready_w[0] && k < 60) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("send_accept", 32'(k < 60), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_last(input int target);
      for (int k = 0; k < 60 && last_cnt < target; k++) @(negedge clk);
      check("last_beat_seen", 32'(last_cnt), 32'(target));
      @(negedge clk);
   endtask

   function automatic logic [31:0] model_step(input logic [31:0] s, input logic [15:0] d);
      logic [31:0] r;
      r = s;
      for (int b = 0; b < 16; b++) begin
         r = {r[30:0], d[b]} ^ (r[31] ? 32'h741B8CD7 : 32'h0);
      end
      return r;
   endfunction

   initial begin
      logic [15:0] w [4];
      logic [31:0] exp_crc;
      int          done_before;
      int          last_before;

      rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 4; i++) done_cnt[i] = 0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_m_valid", 32'(m_valid_w[0]), 32'd0);
      check("rst_m_last", 32'(m_last_w[0]), 32'd0);
      check("rst_m_data", 32'(m_data_w[0]), 32'h0);
      check("rst_crc_out", crc_out_w[0], 32'h0);
      check("rst_crc_done", 32'(crc_done_w[0]), 32'd0);
      check("rst_s_ready", 32'(s_ready_w[0]), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single-word frame; also exercises FINAL_XOR on instance 2
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      send(16'h0001, 1'b1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_last(1);
      check("t1_len", 32'(q0.size()), 32'd3);
      check("t1_w0", 32'(q0[0]), {15'h0, 17'h0_0001});
      check("t1_w1", 32'(q0[1]), {15'h0, 17'h0_0000});
      check("t1_w2", 32'(q0[2]), {15'h0, 17'h1_8000});
      check("t1_crc_out", crc_out_w[0], 32'h0000_8000);
      check("t1_done_pulses", 32'(done_cnt[0]), 32'd1);
      check("t6_hi", 32'(q2[1]), {15'h0, 17'h0_FFFF});
      check("t6_lo", 32'(q2[2]), {15'h0, 17'h1_7FFF});
      check("t6_crc_out", crc_out_w[2], 32'hFFFF_7FFF);

      // Feedback tap check
      q1.delete();
      send(16'h0000, 1'b1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_last(2);
      check("t2_w0", 32'(q1[0]), {15'h0, 17'h0_0000});
      check("t2_hi", 32'(q1[1]), {15'h0, 17'h0_741B});
      check("t2_lo", 32'(q1[2]), {15'h0, 17'h1_8CD7});
      check("t2_crc_out", crc_out_w[1], 32'h741B_8CD7);

      // Backpressure: three stalled cycles with the second word waiting
      q0.delete();
      @(negedge clk);
      s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b0; m_ready = 1'b1;
      #1;
      check("t3_ready_first", 32'(s_ready_w[0]), 32'd1);
      @(negedge clk);
      s_data = 16'h0000; s_last = 1'b1; m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_stall_data", 32'(m_data_w[0]), 32'h0001);
         check("t3_stall_ready", 32'(s_ready_w[0]), 32'd0);
         check("t3_stall_valid", 32'(m_valid_w[0]), 32'd1);
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      check("t3_ready_release", 32'(s_ready_w[0]), 32'd1);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      wait_last(3);
      check("t3_len", 32'(q0.size()), 32'd4);
      check("t3_w0", 32'(q0[0]), {15'h0, 17'h0_0001});
      check("t3_w1", 32'(q0[1]), {15'h0, 17'h0_0000});
      check("t3_hi", 32'(q0[2]), {15'h0, 17'h0_8000});
      check("t3_lo", 32'(q0[3]), {15'h0, 17'h1_0000});
      check("t3_crc_out", crc_out_w[0], 32'h8000_0000);

      // Back-to-back frames with the default INIT
      w[0] = 16'h1234; w[1] = 16'hABCD; w[2] = 16'h0F0F; w[3] = 16'h8001;
      exp_crc = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) exp_crc = model_step(exp_crc, w[i]);
      q3.delete();
      done_before = done_cnt[3];
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 4; i++) begin
            send(w[i], i == 3);
            if (f == 1 && i == 0) check("t4_b2b_accept_cycle", 32'(acc_cyc), 32'(mlast_cyc));
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      wait_last(5);
      check("t4_len", 32'(q3.size()), 32'd12);
      check("t4_f0_w0", 32'(q3[0]), {15'h0, 1'b0, w[0]});
      check("t4_f0_hi", 32'(q3[4]), {15'h0, 1'b0, exp_crc[31:16]});
      check("t4_f0_lo", 32'(q3[5]), {15'h0, 1'b1, exp_crc[15:0]});
      check("t4_f1_hi", 32'(q3[10]), {15'h0, 1'b0, exp_crc[31:16]});
      check("t4_f1_lo", 32'(q3[11]), {15'h0, 1'b1, exp_crc[15:0]});
      check("t4_crc_out", crc_out_w[3], exp_crc);
      check("t4_done_pulses", 32'(done_cnt[3] - done_before), 32'd2);

      // Reset mid-frame drops the partial frame
      send(16'h1111, 1'b0);
      send(16'h2222, 1'b0);
      s_valid = 1'b0;
      done_before = done_cnt[0];
      last_before = last_cnt;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t5_m_valid_after_rst", 32'(m_valid_w[0]), 32'd0);
      repeat (6) @(negedge clk);
      check("t5_no_crc_done", 32'(done_cnt[0]), 32'(done_before));
      check("t5_no_last", 32'(last_cnt), 32'(last_before));
      q0.delete();
      send(16'h0001, 1'b1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_last(last_before + 1);
      check("t5_len", 32'(q0.size()), 32'd3);
      check("t5_hi", 32'(q0[1]), {15'h0, 17'h0_0000});
      check("t5_lo", 32'(q0[2]), {15'h0, 17'h1_8000});
      check("t5_crc_out", crc_out_w[0], 32'h0000_8000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
